branch_resolver: RTL
====================

# branch_resolver

Resolves conditional branches in EX and closes the loop with the 2-bit branch predictor. Captures each ID-stage branch's prediction into a small in-order FIFO, evaluates the real condition when the branch reaches EX, and drives the predictor's outcome/enable pair. On a wrong guess it raises a one-cycle flush with the correct redirect PC. Sits between the ID/EX pipeline registers and the predictor/fetch unit.

## Interface
Parameters:
- DEPTH, 4, in-flight branch FIFO entries (power of two, 2..8)
- XLEN, 32, operand and PC width

Ports:
- clk  in  1  pipeline clock
- Reset  in  1  synchronous, active-high
- id_valid  in  1  ID instruction valid and advancing (not stalled)
- id_opcode  in  7  ID opcode
- id_prediction  in  1  predictor output for this ID instruction (1 = taken)
- ex_valid  in  1  EX instruction valid
- ex_opcode  in  7  EX opcode
- ex_funct3  in  3  EX branch condition
- ex_rs1, ex_rs2  in  XLEN  forwarded operands
- ex_pc  in  XLEN  branch PC
- ex_target  in  XLEN  computed branch target
- bp_enable  out  1  one-cycle predictor update strobe
- outcome  out  2  00 idle, 01 not taken, 10 taken; 11 never driven
- flush  out  1  squash IF/ID, one cycle
- redirect_pc  out  XLEN  correct next PC, valid while flush = 1
- overflow_err, underflow_err  out  1  sticky error flags

## Operation
- Branch = opcode 7'b1100011. Push id_prediction when id_valid and ID opcode is a branch. Pop when ex_valid and EX opcode is a branch.
- Condition by funct3: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU. 010/011 → not taken.
- actual = condition result; predicted = popped entry. mispredict = actual != predicted.
- redirect_pc = actual ? ex_target : ex_pc + 4 (mod 2^XLEN).
- Every resolved branch: bp_enable = 1 and outcome = {actual, ~actual}, regardless of mispredict.
- On mispredict, FIFO is cleared after the pop. A push in the same cycle is discarded, since it is a wrong-path instruction.
- Simultaneous push and pop without mispredict: count unchanged, and both pointers advance.
- Push when full and no pop: entry dropped, overflow_err set.
- Pop when empty: predicted taken as 0 (not taken), underflow_err set.
- Error flags clear only on Reset.
- FIFO state: count 0..DEPTH, rd_ptr, wr_ptr, each wrapping modulo DEPTH.

## Timing
- Resolution latency is 1 cycle. bp_enable, outcome, flush and redirect_pc are registered and valid the cycle after the EX pop.
- flush is high exactly 1 cycle per mispredict. Between resolutions: bp_enable = 0, outcome = 00, flush = 0, and redirect_pc holds its last value.
- FIFO push and pop take effect at the clock edge. A pushed entry can be popped on the next cycle at the earliest.
- Reset values: bp_enable 0, outcome 00, flush 0, redirect_pc 0, both error flags 0, count 0, pointers 0.
- Reset asserted mid-operation discards all in-flight entries and any pending registered outputs at that edge.

## Configuration
- BRU_STATS_EN defined: adds outputs branch_count[15:0] and mispredict_count[15:0].
  - branch_count increments per resolved branch; mispredict_count per mispredict.
  - Both saturate at 16'hFFFF, reset to 0, and update in the same cycle as bp_enable.
- BRU_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset → all outputs 0, outcome 00. Then push pred = 1 and pop BEQ with rs1 = rs2 = 5 → next cycle bp_enable = 1, outcome 10, flush = 0.
- Push pred = 1, pop BNE with rs1 = rs2 = 7, ex_pc = 0x100 → flush = 1 for one cycle, redirect_pc = 0x104, outcome 01.
- Push pred = 0, pop BLT with rs1 = 0xFFFFFFFF, rs2 = 1, ex_target = 0x80 → taken, flush = 1, redirect_pc = 0x80. The same operands under BLTU → not taken, no flush.
- Push DEPTH + 1 branches with no pops → overflow_err = 1, and DEPTH pops return the first DEPTH predictions in order.
- Three entries queued, the first pop mispredicts while an ID push arrives in the same cycle → FIFO count 0 next cycle. A subsequent pop sets underflow_err = 1 and resolves as predicted not taken.
- With BRU_STATS_EN: 5 branches, 2 mispredicts → branch_count = 5, mispredict_count = 2. Force 65537 branches → branch_count stays 0xFFFF.

Source files
------------

// File: rtl/branch_resolver.sv
// branch_resolver
//   Resolves conditional branches in EX against the prediction captured in ID
//   and drives the 2-bit predictor update plus the front-end flush/redirect.
//   ID-stage predictions wait in a small in-order FIFO until their branch
//   reaches EX.
//
// Parameters: DEPTH (in-flight branches, power of two 2..8), XLEN (data width)
// Ports:
//   clk, Reset                   clock, synchronous active-high reset
//   id_valid/id_opcode/id_prediction   ID branch capture
//   ex_valid/ex_opcode/ex_funct3       EX branch resolution
//   ex_rs1/ex_rs2/ex_pc/ex_target      EX operands, branch PC and target
//   bp_enable, outcome           predictor update strobe / {taken, not taken}
//   flush, redirect_pc           one-cycle squash and corrected next PC
//   overflow_err, underflow_err  sticky FIFO error flags
// Optional feature macro: BRU_STATS_EN adds branch_count and
//   mispredict_count (16-bit, saturating).
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic            id_prediction,
   input  logic            ex_valid,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   output logic            bp_enable,
   output logic [1:0]      outcome,
   output logic            flush,
   output logic [XLEN-1:0] redirect_pc,
   output logic            overflow_err,
   output logic            underflow_err
`ifdef BRU_STATS_EN
   ,
   output logic [15:0]     branch_count,
   output logic [15:0]     mispredict_count
`endif
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] pred_mem;
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;

   logic push, pop, empty, full, pop_ok, push_ok;
   logic predicted, actual, mispredict;

   always_comb begin
      push    = id_valid && (id_opcode == OP_BRANCH);
      pop     = ex_valid && (ex_opcode == OP_BRANCH);
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      pop_ok  = pop && !empty;
      // When full, a same-cycle pop frees the slot the push needs.
      push_ok = push && (!full || pop_ok);
      // Popping an empty FIFO resolves as if predicted not taken.
      predicted = empty ? 1'b0 : pred_mem[rd_ptr];
   end

   always_comb begin
      actual = 1'b0;
      unique case (ex_funct3)
         3'b000:  actual = (ex_rs1 == ex_rs2);
         3'b001:  actual = (ex_rs1 != ex_rs2);
         3'b100:  actual = ($signed(ex_rs1) <  $signed(ex_rs2));
         3'b101:  actual = ($signed(ex_rs1) >= $signed(ex_rs2));
         3'b110:  actual = (ex_rs1 <  ex_rs2);
         3'b111:  actual = (ex_rs1 >= ex_rs2);
         default: actual = 1'b0;
      endcase
      mispredict = pop && (actual != predicted);
   end

   // Resolution outputs, registered one cycle after the EX pop.
   always_ff @(posedge clk) begin
      if (Reset) begin
         bp_enable   <= 1'b0;
         outcome     <= 2'b00;
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         bp_enable <= pop;
         outcome   <= pop ? {actual, ~actual} : 2'b00;
         flush     <= mispredict;
         if (pop)
            redirect_pc <= actual ? ex_target : ex_pc + XLEN'(4);
      end
   end

   // Prediction FIFO and sticky error flags.
   always_ff @(posedge clk) begin
      if (Reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (mispredict) begin
            // Everything behind the mispredicted branch, including a
            // same-cycle push, is wrong-path.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop_ok)
               rd_ptr <= rd_ptr + PW'(1);
            if (push_ok)
               wr_ptr <= wr_ptr + PW'(1);
            case ({push_ok, pop_ok})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
         if (push && full && !pop)
            overflow_err <= 1'b1;
         if (pop && empty)
            underflow_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!Reset && !mispredict && push_ok)
         pred_mem[wr_ptr] <= id_prediction;
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge clk) begin
      if (Reset) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else if (pop) begin
         if (branch_count != 16'hFFFF)
            branch_count <= branch_count + 16'd1;
         if (mispredict && mispredict_count != 16'hFFFF)
            mispredict_count <= mispredict_count + 16'd1;
      end
   end
`endif

endmodule
